tt_um_uabc_test2024: RTL and testbench

TT_UM_UABC_TEST2024 -- requirements
Module: tt_um_uabc_test2024

---
 rtl/tt_um_uabc_test2024_pkg.sv | 55 +++++
 rtl/tt_um_uabc_test2024_seg7_decoder.sv | 21 ++
 rtl/tt_um_uabc_test2024.sv | 112 +++++++++++
 tb/tb_tt_um_uabc_test2024.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/tt_um_uabc_test2024_pkg.sv
// -----------------------------------------------------------------------------
// tt_um_uabc_test2024_pkg
// Shared constants for the hex up/down counter with seven-segment output:
//   - bit positions of the control fields inside ui_in
//   - default prescale ratio (clk cycles per count tick in normal mode)
//   - width of the prescaler register
//   - 16-entry seven-segment table, segments a..g on bits 0..6, active-high
//   - count direction encoding
// -----------------------------------------------------------------------------
package tt_um_uabc_test2024_pkg;

    // Control field positions within ui_in
    localparam int UI_EN      = 0;   // count enable
    localparam int UI_DIR     = 1;   // 0 = up, 1 = down
    localparam int UI_LOAD    = 2;   // synchronous load strobe
    localparam int UI_FAST    = 3;   // tick every cycle
    localparam int UI_VAL_LSB = 4;   // load value occupies [7:4]

    // One tick per second with a 10 MHz clock
    localparam int unsigned PRESCALE_DEFAULT = 10_000_000;
    localparam int          PRESC_W          = 24;

    // Direction encoding of ui_in[UI_DIR]
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Segment patterns, g..a on bits 6..0, indexed by hex digit.
    // Lower-case b and d keep them distinguishable from 8 and 0.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71,  // F
        7'h79,  // E
        7'h5E,  // d
        7'h39,  // C
        7'h7C,  // b
        7'h77,  // A
        7'h6F,  // 9
        7'h7F,  // 8
        7'h07,  // 7
        7'h7D,  // 6
        7'h6D,  // 5
        7'h66,  // 4
        7'h4F,  // 3
        7'h5B,  // 2
        7'h06,  // 1
        7'h3F   // 0
    };

    // Look up the segment pattern for one hex digit
    function automatic logic [6:0] seg_of(input logic [3:0] digit);
        return SEG_TABLE[digit];
    endfunction

endpackage : tt_um_uabc_test2024_pkg

// File: rtl/tt_um_uabc_test2024_seg7_decoder.sv
// -----------------------------------------------------------------------------
// seg7_decoder
// Purely combinational hex-digit to seven-segment decoder.
// Ports:
//   digit_i [3:0]  hex digit to display
//   seg_o   [6:0]  segments a..g on bits 0..6, active-high
// -----------------------------------------------------------------------------
module seg7_decoder
    import tt_um_uabc_test2024_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
        seg_o = 7'h00;
        seg_o = seg_of(digit_i);
    end

endmodule : seg7_decoder

// File: rtl/tt_um_uabc_test2024.sv
// -----------------------------------------------------------------------------
// tt_um_uabc_test2024
// 4-bit hex up/down counter shown on a seven-segment display. A prescaler
// divides clk down to a count tick (or ticks every cycle in fast mode); the
// decimal point toggles on every enabled tick as a heartbeat.
// Ports:
//   clk            system clock, all state on its rising edge
//   rst_n          synchronous reset, ACTIVE-HIGH despite the name (pin name kept)
//   ena            design-selected flag, ignored
//   ui_in   [7:0]  [0] enable, [1] direction, [2] load, [3] fast, [7:4] load value
//   uo_out  [7:0]  [6:0] segments a..g, [7] decimal point (heartbeat)
//   uio_in  [7:0]  unused
//   uio_out [7:0]  constant 0
//   uio_oe  [7:0]  constant 0 (bidirectional pins are inputs)
// -----------------------------------------------------------------------------
module tt_um_uabc_test2024
    import tt_um_uabc_test2024_pkg::*;
#(
    parameter int unsigned PRESCALE = PRESCALE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    // Terminal prescaler value; PRESCALE may be 2^24, whose terminal count
    // still fits the 24-bit register.
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESCALE - 1);

    // Decoded control inputs
    logic       en;
    logic       load;
    logic       fast;
    dir_e       dir;
    logic [3:0] load_val;

    assign en       = ui_in[UI_EN];
    assign load     = ui_in[UI_LOAD];
    assign fast     = ui_in[UI_FAST];
    assign dir      = dir_e'(ui_in[UI_DIR]);
    assign load_val = ui_in[UI_VAL_LSB +: 4];

    // State
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [3:0]         count_q, count_d;
    logic               dp_q,    dp_d;
    logic               tick;

    // Fast mode ticks every cycle; otherwise tick on the terminal count
    assign tick = fast | (presc_q == PRESC_MAX);

    always_comb begin
        presc_d = presc_q;
        count_d = count_q;
        dp_d    = dp_q;

        // Prescaler: held at 0 in fast mode and cleared by a load, so a load
        // restarts a full prescale period.
        if (load || fast || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 1'b1;
        end

        // Count: load has priority over enable and tick
        if (load) begin
            count_d = load_val;
        end else if (tick && en) begin
            count_d = (dir == DIR_DOWN) ? count_q - 4'd1 : count_q + 4'd1;
        end

        // Heartbeat follows enabled ticks only and ignores load
        if (tick && en) begin
            dp_d = ~dp_q;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so all registers update from the same pre-edge values.
        if (rst_n) begin
            presc_q <= '0;
            count_q <= '0;
            dp_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
            dp_q    <= dp_d;
        end
    end

    // Output wiring
    logic [6:0] seg;

    seg7_decoder u_seg7_decoder (
        .digit_i (count_q),
        .seg_o   (seg)
    );

    assign uo_out  = {dp_q, seg};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    // ena and uio_in are intentionally unused
    logic unused_inputs;
    assign unused_inputs = &{1'b0, ena, uio_in};

endmodule : tt_um_uabc_test2024

// File: tb/tb_tt_um_uabc_test2024.sv
// -----------------------------------------------------------------------------
// tb_tt_um_uabc_test2024
// Directed self-checking bench for the hex counter. The DUT runs with
// PRESCALE = 4 so normal-mode ticking is visible in a few cycles; fast-mode
// scenarios do not depend on the prescale ratio.
// -----------------------------------------------------------------------------
module tb_tt_um_uabc_test2024;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int errors = 0;
    int checks = 0;

    // Hand-typed segment patterns, digit 0..F
    logic [6:0] exp_seg [16];
    initial begin
        exp_seg[0]  = 7'h3F; exp_seg[1]  = 7'h06; exp_seg[2]  = 7'h5B; exp_seg[3]  = 7'h4F;
        exp_seg[4]  = 7'h66; exp_seg[5]  = 7'h6D; exp_seg[6]  = 7'h7D; exp_seg[7]  = 7'h07;
        exp_seg[8]  = 7'h7F; exp_seg[9]  = 7'h6F; exp_seg[10] = 7'h77; exp_seg[11] = 7'h7C;
        exp_seg[12] = 7'h39; exp_seg[13] = 7'h5E; exp_seg[14] = 7'h79; exp_seg[15] = 7'h71;
    end

    tt_um_uabc_test2024 #(
        .PRESCALE (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle; inputs changed after this are
    // stable well before the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        ena    = 1'b1;
        uio_in = 8'h00;
        ui_in  = 8'h00;
        rst_n  = 1'b1;
        step();
        step();
        checks++;
        if (uo_out !== 8'h3F) begin
            errors++;
            $display("FAIL reset_uo_out: got %02h expected 3F", uo_out);
        end
        checks++;
        if (uio_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_uio_out: got %02h expected 00", uio_out);
        end
        checks++;
        if (uio_oe !== 8'h00) begin
            errors++;
            $display("FAIL reset_uio_oe: got %02h expected 00", uio_oe);
        end
        rst_n = 1'b0;
    endtask

    // Fast up count from 0: 19 ticks take 0 through F, wrap, and end on 3
    task automatic test_fast_up();
        logic [3:0] cnt;
        logic       dp;
        cnt   = 4'd0;
        dp    = 1'b0;
        ui_in = 8'h09;
        checks++;
        if (uo_out !== 8'h3F) begin
            errors++;
            $display("FAIL fast_up_start: got %02h expected 3F", uo_out);
        end
        for (int i = 0; i < 19; i++) begin
            step();
            cnt = cnt + 4'd1;
            dp  = ~dp;
            checks++;
            if (uo_out !== {dp, exp_seg[cnt]}) begin
                errors++;
                $display("FAIL fast_up_%0d: got %02h expected %02h", i, uo_out, {dp, exp_seg[cnt]});
            end
        end
    endtask

    // Load 3 with enable low (dp must not move), then fast count down through wrap
    task automatic test_load_down();
        logic dp;
        logic [3:0] seq [4];
        seq[0] = 4'h2; seq[1] = 4'h1; seq[2] = 4'h0; seq[3] = 4'hF;
        dp    = 1'b1;                   // 19 toggles in the previous test
        ui_in = 8'h34;
        step();
        checks++;
        if (uo_out !== {dp, 7'h4F}) begin
            errors++;
            $display("FAIL load_3: got %02h expected %02h", uo_out, {dp, 7'h4F});
        end
        ui_in = 8'h0B;
        for (int i = 0; i < 4; i++) begin
            step();
            dp = ~dp;
            checks++;
            if (uo_out !== {dp, exp_seg[seq[i]]}) begin
                errors++;
                $display("FAIL down_%0d: got %02h expected %02h", i, uo_out, {dp, exp_seg[seq[i]]});
            end
        end
    endtask

    // Normal mode with PRESCALE = 4: advance every 4th edge after reset release,
    // freeze while disabled, then reverse direction on the next tick.
    task automatic test_normal();
        logic [3:0] cnt;
        logic       dp;
        rst_n = 1'b1;
        ui_in = 8'h00;
        step();
        rst_n = 1'b0;
        ui_in = 8'h01;
        cnt   = 4'd0;
        dp    = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k % 4 == 0) begin
                cnt = cnt + 4'd1;
                dp  = ~dp;
            end
            checks++;
            if (uo_out !== {dp, exp_seg[cnt]}) begin
                errors++;
                $display("FAIL normal_k%0d: got %02h expected %02h", k, uo_out, {dp, exp_seg[cnt]});
            end
        end
        // Disabled: count 3 and dp 1 hold while the prescaler keeps running
        ui_in = 8'h00;
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++;
            if (uo_out !== 8'hCF) begin
                errors++;
                $display("FAIL freeze_k%0d: got %02h expected CF", k, uo_out);
            end
        end
        // Prescaler is back at phase 0; down count takes effect on the 4th edge
        ui_in = 8'h03;
        step(); step(); step();
        checks++;
        if (uo_out !== 8'hCF) begin
            errors++;
            $display("FAIL dir_before_tick: got %02h expected CF", uo_out);
        end
        step();
        checks++;
        if (uo_out !== 8'h5B) begin
            errors++;
            $display("FAIL dir_on_tick: got %02h expected 5B", uo_out);
        end
    endtask

    // Reset while counting in fast mode; ena and uio_in are scrambled to show
    // they have no effect.
    task automatic test_reset_mid();
        ena    = 1'b0;
        uio_in = 8'hA5;
        ui_in  = 8'h7C;                 // load 7, fast, enable low
        step();
        checks++;
        if (uo_out[6:0] !== 7'h07) begin
            errors++;
            $display("FAIL mid_load_7: got %02h expected 07", uo_out[6:0]);
        end
        ui_in = 8'h09;
        rst_n = 1'b1;
        step();
        checks++;
        if (uo_out !== 8'h3F) begin
            errors++;
            $display("FAIL mid_reset: got %02h expected 3F", uo_out);
        end
        rst_n = 1'b0;
        step();
        checks++;
        if (uo_out !== 8'h86) begin
            errors++;
            $display("FAIL mid_resume_1: got %02h expected 86", uo_out);
        end
        step();
        checks++;
        if (uo_out !== 8'h5B) begin
            errors++;
            $display("FAIL mid_resume_2: got %02h expected 5B", uo_out);
        end
        checks++;
        if ({uio_out, uio_oe} !== 16'h0000) begin
            errors++;
            $display("FAIL mid_uio: got %04h expected 0000", {uio_out, uio_oe});
        end
    endtask

    initial begin
        rst_n  = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        #1;
        test_reset();
        test_fast_up();
        test_load_down();
        test_normal();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_tt_um_uabc_test2024
